// File: rtl/lsu_dmem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_dmem_ctrl : load/store controller in front of the data memory;        |
// |                 checks size/alignment/range, drives a req/gnt/rvalid port. |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module lsu_dmem_ctrl #(
  parameter logic [31:0] DMEM_BASE   = 32'h0000_4000,
  parameter int unsigned DMEM_BYTES  = 49152,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        core_valid,
  output logic        core_ready,
  input  logic        core_we,
  input  logic [1:0]  core_n_bytes,
  input  logic        core_unsigned,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  localparam logic [1:0]  c_nb_word   = 2'b00;
  localparam logic [1:0]  c_nb_half   = 2'b10;
  localparam logic [1:0]  c_nb_byte   = 2'b01;
  localparam logic [1:0]  c_err_ok    = 2'b00;
  localparam logic [1:0]  c_err_align = 2'b01;
  localparam logic [1:0]  c_err_range = 2'b10;
  localparam logic [1:0]  c_err_tmo   = 2'b11;
  localparam int          c_cw        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_cw-1:0] c_cnt_last = c_cw'(TIMEOUT_CYC - 1);
  localparam logic [32:0] c_dmem_end  = {1'b0, DMEM_BASE} + 33'(DMEM_BYTES);

  state_e            state_q, state_d;
  logic [c_cw-1:0]   cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        nb_q, nb_d;
  logic              uns_q, uns_d;
  logic [1:0]        off_q, off_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [2:0]        w_size;
  logic [3:0]        w_be;
  logic              w_misalign;
  logic              w_range;
  logic [31:0]       w_lane;
  logic [31:0]       w_ext;

  // Request decode, only meaningful while IDLE is sampling core_*.
  always_comb begin
    w_size = 3'd4;
    w_be   = 4'b1111;
    case (core_n_bytes)
      c_nb_byte: begin
        w_size = 3'd1;
        w_be   = 4'b0001 << core_addr[1:0];
      end
      c_nb_half: begin
        w_size = 3'd2;
        w_be   = 4'b0011 << core_addr[1:0];
      end
      default: begin
        w_size = 3'd4;
        w_be   = 4'b1111;
      end
    endcase
  end

  assign w_misalign = (core_n_bytes == 2'b11)
                    || ((core_n_bytes == c_nb_word) && (core_addr[1:0] != 2'b00))
                    || ((core_n_bytes == c_nb_half) && core_addr[0]);
  // 33-bit sum so an access near 4 GiB cannot wrap back into range.
  assign w_range    = (core_addr < DMEM_BASE)
                    || (({1'b0, core_addr} + 33'(w_size)) > c_dmem_end);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    nb_d    = nb_q;
    uns_d   = uns_q;
    off_d   = off_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (core_valid) begin
          we_d    = core_we;
          nb_d    = core_n_bytes;
          uns_d   = core_unsigned;
          off_d   = core_addr[1:0];
          addr_d  = {core_addr[31:2], 2'b00};
          be_d    = w_be;
          wdata_d = core_wdata << {core_addr[1:0], 3'b000};
          rdata_d = '0;
          cnt_d   = '0;
          if (w_misalign) begin
            err_d   = c_err_align;
            state_d = S_RESP;
          end else if (w_range) begin
            err_d   = c_err_range;
            state_d = S_RESP;
          end else begin
            err_d   = c_err_ok;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt && (we_q || mem_rvalid)) begin
          if (!we_q) rdata_d = mem_rdata;
          state_d = S_RESP;
        end else if (cnt_q == c_cnt_last) begin
          err_d   = c_err_tmo;
          state_d = S_RESP;
        end else if (mem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = S_RESP;
        end else if (cnt_q == c_cnt_last) begin
          err_d   = c_err_tmo;
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      nb_q    <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      err_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      nb_q    <= nb_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign w_lane = rdata_q >> {off_q, 3'b000};

  always_comb begin
    w_ext = w_lane;
    case (nb_q)
      c_nb_byte: w_ext = uns_q ? {24'h0, w_lane[7:0]}  : {{24{w_lane[7]}}, w_lane[7:0]};
      c_nb_half: w_ext = uns_q ? {16'h0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]};
      default:   w_ext = w_lane;
    endcase
  end

  assign core_ready = (state_q == S_IDLE);
  assign mem_req    = (state_q == S_REQ);
  assign mem_we     = mem_req && we_q;
  assign mem_addr   = mem_req ? addr_q  : 32'h0;
  assign mem_be     = mem_req ? be_q    : 4'h0;
  assign mem_wdata  = mem_req ? wdata_q : 32'h0;
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid ? err_q : 2'b00;
  assign resp_rdata = (resp_valid && !we_q && (err_q == c_err_ok)) ? w_ext : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsu_dmem_ctrl : scoreboard bench with a configurable memory responder.  |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_lsu_dmem_ctrl;

  localparam logic [1:0] c_nb_w = 2'b00;
  localparam logic [1:0] c_nb_h = 2'b10;
  localparam logic [1:0] c_nb_b = 2'b01;
  localparam logic [1:0] c_nb_x = 2'b11;

  logic        clk = 1'b0;
  logic        rstn;
  logic        core_valid, core_ready, core_we, core_unsigned;
  logic [1:0]  core_n_bytes;
  logic [31:0] core_addr, core_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  lsu_dmem_ctrl #(
    .DMEM_BASE  (32'h0000_4000),
    .DMEM_BYTES (49152),
    .TIMEOUT_CYC(16)
  ) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .core_valid   (core_valid),
    .core_ready   (core_ready),
    .core_we      (core_we),
    .core_n_bytes (core_n_bytes),
    .core_unsigned(core_unsigned),
    .core_addr    (core_addr),
    .core_wdata   (core_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          nreq;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int          n = 0, accept_n = 0, nreq_cnt = 0, resp_cnt = 0;
  int          gnt_delay = 0, rv_mode = 0, wcnt = 0;
  logic        rv_pend = 1'b0;
  logic [31:0] mem_word = 32'h0;
  logic [31:0] exp_addr = 32'h0, exp_wd = 32'h0;
  logic [3:0]  exp_be = 4'h0;
  logic        exp_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] b);
    logic [31:0] m;
    m = 32'h0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{b[i]}};
    return m;
  endfunction

  // Response monitor: one scoreboard entry is consumed per resp_valid cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      n++;
      if (mem_req) nreq_cnt++;
      if (resp_valid) begin
        resp_cnt++;
        if (sb.size() == 0) begin
          check("unexp_resp", 32'(resp_valid), 32'h0);
        end else begin
          e = sb.pop_front();
          check("rdata", resp_rdata, e.rdata);
          check("err",   32'(resp_err), 32'(e.err));
          check("lat",   32'(n - accept_n), 32'(e.lat));
          check("nreq",  32'(nreq_cnt), 32'(e.nreq));
        end
      end
      if (core_valid && core_ready) begin
        accept_n = n;
        nreq_cnt = 0;
      end
    end
  end

  // Memory responder; also checks the request fields every cycle mem_req is up.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (rv_pend) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem_word;
        rv_pend    = 1'b0;
      end
      if (!mem_req) begin
        wcnt = 0;
      end else begin
        check("mem_addr", mem_addr, exp_addr);
        check("mem_be",   32'(mem_be), 32'(exp_be));
        check("mem_we",   32'(mem_we), 32'(exp_we));
        if (exp_we) check("mem_wdata", mem_wdata & be_mask(exp_be), exp_wd);
        if (wcnt < gnt_delay) begin
          wcnt++;
        end else begin
          mem_gnt = 1'b1;
          wcnt = 0;
          if (!mem_we) begin
            if (rv_mode == 0) rv_pend = 1'b1;
            else if (rv_mode == 1) begin
              mem_rvalid = 1'b1;
              mem_rdata  = mem_word;
            end
          end
        end
      end
    end
  end

  task automatic cfg(input int gd, input int rm, input logic [31:0] w);
    gnt_delay = gd;
    rv_mode   = rm;
    mem_word  = w;
  endtask

  task automatic wait_ready();
    int i;
    for (i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (core_ready) break;
    end
    if (i == 50) check("ready_timeout", 32'(core_ready), 32'h1);
  endtask

  task automatic drive(input logic we, input logic [1:0] nb, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    core_we = we; core_n_bytes = nb; core_unsigned = uns;
    core_addr = addr; core_wdata = wd; core_valid = 1'b1;
    @(posedge clk);
    #1;
    core_valid = 1'b0;
  endtask

  task automatic do_req(input logic we, input logic [1:0] nb, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] mwd,
                        input logic [31:0] rd, input logic [1:0] err,
                        input int lat, input int nreq);
    exp_t e;
    int   i;
    e.rdata = rd; e.err = err; e.lat = lat; e.nreq = nreq;
    sb.push_back(e);
    exp_addr = {addr[31:2], 2'b00};
    exp_be   = be;
    exp_we   = we;
    exp_wd   = mwd;
    wait_ready();
    drive(we, nb, uns, addr, wd);
    for (i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check("resp_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    rstn = 1'b0; core_valid = 1'b0; core_we = 1'b0; core_n_bytes = 2'b00;
    core_unsigned = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
    #12;
    check("rst_ready", 32'(core_ready), 32'h1);
    check("rst_req",   32'(mem_req), 32'h0);
    check("rst_resp",  32'(resp_valid), 32'h0);
    check("rst_outs",  mem_addr | mem_wdata | resp_rdata | 32'(mem_be) | 32'(resp_err), 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // Sign/zero-extended byte loads
    cfg(0, 0, 32'h1234_80FF);
    do_req(1'b0, c_nb_b, 1'b0, 32'h4001, 32'h0, 4'b0010, 32'h0, 32'hFFFF_FF80, 2'b00, 3, 1);
    do_req(1'b0, c_nb_b, 1'b1, 32'h4001, 32'h0, 4'b0010, 32'h0, 32'h0000_0080, 2'b00, 3, 1);
    // Stores
    cfg(0, 0, 32'h0);
    do_req(1'b1, c_nb_h, 1'b0, 32'h4006, 32'h0000_ABCD, 4'b1100, 32'hABCD_0000, 32'h0, 2'b00, 2, 1);
    do_req(1'b1, c_nb_b, 1'b0, 32'h4003, 32'hFFFF_FF5A, 4'b1000, 32'h5A00_0000, 32'h0, 2'b00, 2, 1);
    do_req(1'b1, c_nb_w, 1'b0, 32'hFFFC, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 32'h0, 2'b00, 2, 1);
    // Rejected requests never reach memory
    do_req(1'b0, c_nb_w, 1'b0, 32'h4002, 32'h0, 4'b1111, 32'h0, 32'h0, 2'b01, 1, 0);
    do_req(1'b0, c_nb_w, 1'b0, 32'h0100, 32'h0, 4'b1111, 32'h0, 32'h0, 2'b10, 1, 0);
    do_req(1'b0, c_nb_x, 1'b0, 32'h4000, 32'h0, 4'b1111, 32'h0, 32'h0, 2'b01, 1, 0);
    do_req(1'b0, c_nb_w, 1'b0, 32'h1_0000, 32'h0, 4'b1111, 32'h0, 32'h0, 2'b10, 1, 0);
    do_req(1'b0, c_nb_b, 1'b0, 32'h3FFF, 32'h0, 4'b1000, 32'h0, 32'h0, 2'b10, 1, 0);
    do_req(1'b0, c_nb_h, 1'b0, 32'h4001, 32'h0, 4'b0110, 32'h0, 32'h0, 2'b01, 1, 0);
    do_req(1'b0, c_nb_w, 1'b0, 32'h0002, 32'h0, 4'b1111, 32'h0, 32'h0, 2'b01, 1, 0);
    // Delayed grant with same-cycle rvalid
    cfg(3, 1, 32'hDEAD_BEEF);
    do_req(1'b0, c_nb_w, 1'b0, 32'h4010, 32'h0, 4'b1111, 32'h0, 32'hDEAD_BEEF, 2'b00, 5, 4);
    // Timeout while waiting for rvalid
    cfg(0, 2, 32'h0);
    do_req(1'b0, c_nb_w, 1'b0, 32'h4020, 32'h0, 4'b1111, 32'h0, 32'h0, 2'b11, 17, 1);
    #1 check("ready_after_tmo", 32'(core_ready), 32'h1);
    // Halfword and word loads, last byte of DMEM
    cfg(0, 0, 32'h8001_0000);
    do_req(1'b0, c_nb_h, 1'b0, 32'h4002, 32'h0, 4'b1100, 32'h0, 32'hFFFF_8001, 2'b00, 3, 1);
    do_req(1'b0, c_nb_h, 1'b1, 32'h4002, 32'h0, 4'b1100, 32'h0, 32'h0000_8001, 2'b00, 3, 1);
    cfg(0, 0, 32'h8000_0000);
    do_req(1'b0, c_nb_w, 1'b1, 32'h4000, 32'h0, 4'b1111, 32'h0, 32'h8000_0000, 2'b00, 3, 1);
    cfg(0, 0, 32'h7F00_0000);
    do_req(1'b0, c_nb_b, 1'b0, 32'hFFFF, 32'h0, 4'b1000, 32'h0, 32'h0000_007F, 2'b00, 3, 1);
    // Completion on the final allowed cycle wins; one cycle later times out
    cfg(15, 1, 32'h0BAD_F00D);
    do_req(1'b0, c_nb_w, 1'b0, 32'h4100, 32'h0, 4'b1111, 32'h0, 32'h0BAD_F00D, 2'b00, 17, 16);
    cfg(16, 1, 32'h0BAD_F00D);
    do_req(1'b0, c_nb_w, 1'b0, 32'h4100, 32'h0, 4'b1111, 32'h0, 32'h0, 2'b11, 17, 16);

    // Asynchronous reset while in WAIT, followed by a stale rvalid
    cfg(0, 2, 32'h1111_2222);
    exp_addr = 32'h4040; exp_be = 4'b1111; exp_we = 1'b0; exp_wd = 32'h0;
    wait_ready();
    drive(1'b0, c_nb_w, 1'b0, 32'h4040, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("wait_ready", 32'(core_ready), 32'h0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("arst_ready", 32'(core_ready), 32'h1);
    check("arst_req",   32'(mem_req), 32'h0);
    check("arst_outs",  mem_addr | mem_wdata | resp_rdata | 32'(mem_be) | 32'(resp_err)
                        | 32'(resp_valid) | 32'(mem_we), 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;
    saved = resp_cnt;
    rv_pend = 1'b1;
    repeat (6) @(posedge clk);
    check("late_rvalid", 32'(resp_cnt), 32'(saved));

    cfg(0, 0, 32'h0);
    do_req(1'b1, c_nb_w, 1'b0, 32'h4008, 32'h1234_5678, 4'b1111, 32'h1234_5678, 32'h0, 2'b00, 2, 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_dmem_ctrl.md
Name: lsu_dmem_ctrl

Overview:
Load/store controller sitting directly upstream of the data memory; consumes core load/store requests encoded with the memory_pkg n_bytes codes (WORD=2'b00, HALFWORD=2'b10, BYTE=2'b01, plus the L_UNSIGNED flag).
Checks alignment and DMEM range, then drives a word-aligned req/gnt/rvalid memory port with byte enables and lane-shifted write data.
Returns sign- or zero-extended load data, or an error code, to the core as a one-cycle response.

Parameters:
DMEM_BASE, 32'h0000_4000, first DMEM byte address (IMEM_BYTES)
DMEM_BYTES, 49152, DMEM size in bytes (MEM_BYTES-IMEM_BYTES)
TIMEOUT_CYC, 16, max cycles in REQ+WAIT before timeout error; must be >=2

Ports:
clk  in  1  clock, all state on rising edge
rstn  in  1  reset; asynchronous, active-low
core_valid  in  1  request valid
core_ready  out  1  controller can accept a request
core_we  in  1  1=store, 0=load
core_n_bytes  in  2  e_mem_num_bytes encoding; 2'b11 is illegal
core_unsigned  in  1  L_UNSIGNED; ignored for stores and WORD
core_addr  in  32  byte address
core_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  2  00 ok, 01 misaligned/illegal size, 10 out of DMEM range, 11 timeout
mem_req  out  1  memory request
mem_we  out  1  write enable
mem_addr  out  32  word address (core_addr with [1:0]=0)
mem_be  out  4  byte enables
mem_wdata  out  32  lane-shifted store data
mem_gnt  in  1  request accepted this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read word

Behaviour:
- Reset (rstn=0, async): state IDLE, timeout counter 0, all outputs 0 except core_ready=1. mem_req drops immediately; an in-flight memory transaction is abandoned and later gnt/rvalid is ignored.
- States: IDLE, REQ, WAIT, RESP. core_ready=1 only in IDLE. resp_valid=1 only in RESP, for exactly one cycle. The response has no backpressure.
- IDLE: on core_valid=1, capture all core_* inputs.
  - Error check, in priority order:
    - n_bytes=11, WORD with addr[1:0]!=0, or HALFWORD with addr[0]!=0 -> err 01.
    - addr<DMEM_BASE or addr+size>DMEM_BASE+DMEM_BYTES -> err 10.
  - Any error -> RESP with err set; no memory access.
  - No error -> REQ.
- REQ: mem_req=1, with mem_we/addr/be/wdata held stable until mem_gnt.
  - gnt on a store -> RESP.
  - gnt on a load without rvalid -> WAIT.
  - gnt on a load with rvalid in the same cycle -> capture data, RESP.
- WAIT: mem_req=0. mem_rvalid -> capture mem_rdata, RESP.
- RESP -> IDLE next cycle. A new request is accepted no earlier than the cycle after resp_valid.
- Timeout counter:
  - Cleared on accept; increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYC without completion -> RESP with err 11 and mem_req deasserted.
  - Completion in the same cycle as the limit wins (err 00).
- Byte enables:
  - BYTE: 4'b0001<<addr[1:0].
  - HALFWORD: 4'b0011<<addr[1:0].
  - WORD: 4'b1111.
  - mem_be is also driven for loads.
- Write data: mem_wdata = core_wdata<<(8*addr[1:0]), bits above the access size replicated don't-care; the bench checks enabled lanes only.
- Load data: lane = mem_rdata>>(8*addr[1:0]).
  - BYTE: lane[7:0], sign-extended unless unsigned.
  - HALFWORD: lane[15:0], extended the same way.
  - WORD: lane unchanged.
- Latency, zero-wait memory (gnt in first REQ cycle, rvalid the cycle after):
  - Store: accept T0, REQ T1, resp_valid T2.
  - Load: resp_valid T3.
- core_valid while not in IDLE is ignored (core_ready=0).

Test Plan:
- LB from 0x4001, mem_rdata=0x1234_80FF, unsigned=0 -> mem_addr 0x4000, be 0010, resp_rdata 0xFFFF_FF80, err 00; same with unsigned=1 -> 0x0000_0080.
- SH 0x0000_ABCD to 0x4006, gnt immediate -> mem_be 1100, mem_wdata[31:16]=0xABCD, mem_we=1, resp_valid at T2, err 00.
- LW at 0x4002 -> resp err 01 at T1, mem_req never asserted; LW at 0x0000_0100 -> err 10; n_bytes=11 -> err 01.
- LW at 0x4010, gnt withheld for 3 cycles, then gnt+rvalid together with rdata 0xDEAD_BEEF -> mem_req stable for 4 cycles, resp_rdata 0xDEAD_BEEF, err 00.
- LW with gnt but no rvalid, TIMEOUT_CYC=16 -> resp err 11 after 16 REQ/WAIT cycles, rdata 0, then IDLE with core_ready=1.
- rstn pulsed low while in WAIT -> all outputs 0 and core_ready=1 asynchronously; a late rvalid produces no resp_valid.
